// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - operand forwarding scoreboard with load-use stall detection
module fwd_scoreboard #(
    parameter int REGW       = 5,
    parameter int DATAW      = 32,
    parameter int NSRC       = 3,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int CNTW       = 16,
    parameter int SELW       = $clog2(DEPTH + 1)
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   issue_valid,
    input  logic                   issue_wen,
    input  logic [REGW-1:0]        issue_dest,
    input  logic                   issue_load,
    input  logic                   advance,
    input  logic                   flush,
    input  logic                   perf_clr,
    input  logic [DEPTH*DATAW-1:0] stage_result,
    input  logic [NSRC*REGW-1:0]   src_reg,
    input  logic [NSRC-1:0]        src_used,
    output logic [NSRC*SELW-1:0]   fwd_sel,
    output logic [NSRC*DATAW-1:0]  fwd_data,
    output logic                   stall,
    output logic [SELW-1:0]        occupancy,
    output logic [CNTW-1:0]        stall_count
);

    typedef struct packed {
        logic            valid;
        logic            wen;
        logic [REGW-1:0] dest;
        logic            load;
    } entry_t;

    entry_t e [DEPTH];

    // Scan oldest to youngest so the youngest matching producer is the last to win.
    always_comb begin
        logic            hit;
        int              win;
        logic [REGW-1:0] r;
        fwd_sel  = '0;
        fwd_data = '0;
        stall    = 1'b0;
        hit      = 1'b0;
        win      = 0;
        r        = '0;
        for (int j = 0; j < NSRC; j++) begin
            r   = src_reg[j*REGW +: REGW];
            hit = 1'b0;
            win = 0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (e[i].valid && e[i].wen && (e[i].dest == r) && (r != '0) && src_used[j]) begin
                    hit = 1'b1;
                    win = i;
                end
            end
            if (hit && (win < LOAD_STAGE) && e[win].load) begin
                stall = 1'b1;
            end else if (hit) begin
                fwd_sel[j*SELW +: SELW]    = SELW'(win + 1);
                fwd_data[j*DATAW +: DATAW] = stage_result[win*DATAW +: DATAW];
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (e[i].valid && e[i].wen) begin
                occupancy = occupancy + SELW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                e[i] <= '0;
            end
        end else if (advance) begin
            for (int i = 1; i < DEPTH; i++) begin
                e[i] <= e[i-1];
            end
            // A stalled or flushed decode slot enters the pipe as a bubble.
            if (issue_valid && !stall && !flush) begin
                e[0] <= '{valid: 1'b1, wen: issue_wen, dest: issue_dest, load: issue_load};
            end else begin
                e[0] <= '0;
            end
        end else if (flush) begin
            e[0].valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_count <= '0;
        end else if (perf_clr) begin
            stall_count <= '0;
        end else if (stall && advance && (stall_count != '1)) begin
            stall_count <= stall_count + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - directed self-checking bench for fwd_scoreboard
module tb_fwd_scoreboard;

    localparam int REGW  = 5;
    localparam int DATAW = 32;
    localparam int NSRC  = 3;
    localparam int DEPTH = 3;
    localparam int SELW  = 2;

    logic                   CLK = 1'b0;
    logic                   nRST;
    logic                   issue_valid, issue_wen, issue_load;
    logic [REGW-1:0]        issue_dest;
    logic                   advance, flush, perf_clr;
    logic [DEPTH*DATAW-1:0] stage_result;
    logic [NSRC*REGW-1:0]   src_reg;
    logic [NSRC-1:0]        src_used;
    logic [NSRC*SELW-1:0]   fwd_sel, fwd_sel2;
    logic [NSRC*DATAW-1:0]  fwd_data, fwd_data2;
    logic                   stall, stall2;
    logic [SELW-1:0]        occupancy, occupancy2;
    logic [15:0]            stall_count;
    logic [1:0]             stall_count2;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    fwd_scoreboard dut (
        .CLK(CLK), .nRST(nRST), .issue_valid(issue_valid), .issue_wen(issue_wen),
        .issue_dest(issue_dest), .issue_load(issue_load), .advance(advance), .flush(flush),
        .perf_clr(perf_clr), .stage_result(stage_result), .src_reg(src_reg), .src_used(src_used),
        .fwd_sel(fwd_sel), .fwd_data(fwd_data), .stall(stall), .occupancy(occupancy),
        .stall_count(stall_count)
    );

    fwd_scoreboard #(.CNTW(2)) dut2 (
        .CLK(CLK), .nRST(nRST), .issue_valid(issue_valid), .issue_wen(issue_wen),
        .issue_dest(issue_dest), .issue_load(issue_load), .advance(advance), .flush(flush),
        .perf_clr(perf_clr), .stage_result(stage_result), .src_reg(src_reg), .src_used(src_used),
        .fwd_sel(fwd_sel2), .fwd_data(fwd_data2), .stall(stall2), .occupancy(occupancy2),
        .stall_count(stall_count2)
    );

    function automatic logic [SELW-1:0] sel_of(input int j);
        return fwd_sel[j*SELW +: SELW];
    endfunction

    function automatic logic [DATAW-1:0] data_of(input int j);
        return fwd_data[j*DATAW +: DATAW];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic issue(input logic v, input logic w, input logic [4:0] d, input logic ld);
        issue_valid = v;
        issue_wen   = w;
        issue_dest  = d;
        issue_load  = ld;
    endtask

    task automatic drain();
        issue(0, 0, 0, 0);
        src_used = '0;
        advance  = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        issue(0, 0, 0, 0);
        advance = 1'b1; flush = 1'b0; perf_clr = 1'b0;
        stage_result = {32'h3333_3333, 32'h1111_1111, 32'hDEAD_BEEF};
        src_reg = '0; src_used = '0;
        repeat (2) @(posedge CLK);
        #2 nRST = 1'b1;
        #1;
        checks++; if (fwd_sel !== '0) begin errors++; $display("FAIL reset_sel: got %h expected 0", fwd_sel); end
        checks++; if (fwd_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", fwd_data); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", stall_count); end
    endtask

    task automatic test_alu_forward();
        issue(1, 1, 5, 0);
        tick();
        issue(0, 0, 0, 0);
        src_reg = 15'd5; src_used = 3'b001;
        #1;
        checks++; if (sel_of(0) !== 2'd1) begin errors++; $display("FAIL alu_sel_ex: got %0d expected 1", sel_of(0)); end
        checks++; if (data_of(0) !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_data_ex: got %h expected deadbeef", data_of(0)); end
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL alu_occ: got %0d expected 1", occupancy); end
        tick();
        checks++; if (sel_of(0) !== 2'd2) begin errors++; $display("FAIL alu_sel_mem: got %0d expected 2", sel_of(0)); end
        checks++; if (data_of(0) !== 32'h1111_1111) begin errors++; $display("FAIL alu_data_mem: got %h expected 11111111", data_of(0)); end
        tick();
        checks++; if (sel_of(0) !== 2'd3) begin errors++; $display("FAIL alu_sel_wb: got %0d expected 3", sel_of(0)); end
        checks++; if (data_of(0) !== 32'h3333_3333) begin errors++; $display("FAIL alu_data_wb: got %h expected 33333333", data_of(0)); end
        tick();
        checks++; if (sel_of(0) !== 2'd0) begin errors++; $display("FAIL alu_sel_gone: got %0d expected 0", sel_of(0)); end
        checks++; if (data_of(0) !== 32'd0) begin errors++; $display("FAIL alu_data_gone: got %h expected 0", data_of(0)); end
        src_used = '0;
    endtask

    task automatic test_youngest();
        issue(1, 1, 7, 0);
        tick();
        tick();
        issue(0, 0, 0, 0);
        src_reg = {5'd0, 5'd7, 5'd0}; src_used = 3'b010;
        #1;
        checks++; if (sel_of(1) !== 2'd1) begin errors++; $display("FAIL young_sel: got %0d expected 1", sel_of(1)); end
        checks++; if (data_of(1) !== 32'hDEAD_BEEF) begin errors++; $display("FAIL young_data: got %h expected deadbeef", data_of(1)); end
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL young_occ: got %0d expected 2", occupancy); end
        drain();
    endtask

    task automatic test_mid_reset();
        issue(1, 1, 5, 0);
        tick();
        issue(0, 0, 0, 0);
        src_reg = 15'd5; src_used = 3'b001;
        #1 nRST = 1'b0;
        #1;
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL mreset_occ: got %0d expected 0", occupancy); end
        checks++; if (sel_of(0) !== 2'd0) begin errors++; $display("FAIL mreset_sel: got %0d expected 0", sel_of(0)); end
        nRST = 1'b1;
        tick();
        checks++; if (sel_of(0) !== 2'd0) begin errors++; $display("FAIL mreset_post_sel: got %0d expected 0", sel_of(0)); end
        src_used = '0;
    endtask

    task automatic test_load_use();
        issue(1, 1, 3, 1);
        tick();
        issue(1, 1, 9, 0);
        src_reg = 15'd3; src_used = 3'b001;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", stall); end
        checks++; if (sel_of(0) !== 2'd0) begin errors++; $display("FAIL lu_sel_hazard: got %0d expected 0", sel_of(0)); end
        checks++; if (data_of(0) !== 32'd0) begin errors++; $display("FAIL lu_data_hazard: got %h expected 0", data_of(0)); end
        tick();
        issue(0, 0, 0, 0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_clear: got %b expected 0", stall); end
        checks++; if (sel_of(0) !== 2'd2) begin errors++; $display("FAIL lu_sel: got %0d expected 2", sel_of(0)); end
        checks++; if (data_of(0) !== 32'h1111_1111) begin errors++; $display("FAIL lu_data: got %h expected 11111111", data_of(0)); end
        checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_cnt: got %0d expected 1", stall_count); end
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL lu_occ_bubble: got %0d expected 1", occupancy); end
        drain();
    endtask

    task automatic test_freeze();
        issue(1, 1, 3, 1);
        tick();
        issue(0, 0, 0, 0);
        src_reg = 15'd3; src_used = 3'b001;
        advance = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL frz_stall%0d: got %b expected 1", k, stall); end
            checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL frz_cnt%0d: got %0d expected 1", k, stall_count); end
            checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL frz_occ%0d: got %0d expected 1", k, occupancy); end
        end
        advance = 1'b1;
        tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL frz_rel_stall: got %b expected 0", stall); end
        checks++; if (sel_of(0) !== 2'd2) begin errors++; $display("FAIL frz_rel_sel: got %0d expected 2", sel_of(0)); end
        checks++; if (stall_count !== 16'd2) begin errors++; $display("FAIL frz_rel_cnt: got %0d expected 2", stall_count); end
        drain();
    endtask

    task automatic test_r0();
        issue(1, 1, 0, 1);
        tick();
        issue(0, 0, 0, 0);
        src_reg = 15'd0; src_used = 3'b111;
        #1;
        checks++; if (fwd_sel !== '0) begin errors++; $display("FAIL r0_sel: got %h expected 0", fwd_sel); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall: got %b expected 0", stall); end
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL r0_occ: got %0d expected 1", occupancy); end
        drain();
    endtask

    task automatic test_flush();
        issue(1, 1, 4, 0);
        flush = 1'b1;
        tick();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_adv_occ: got %0d expected 0", occupancy); end
        flush = 1'b0;
        tick();
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL flush_fill_occ: got %0d expected 1", occupancy); end
        issue(0, 0, 0, 0);
        advance = 1'b0; flush = 1'b1;
        tick();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_hold_occ: got %0d expected 0", occupancy); end
        flush = 1'b0;
        drain();
    endtask

    task automatic test_saturate();
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        checks++; if (stall_count2 !== 2'd0) begin errors++; $display("FAIL sat_clr0: got %0d expected 0", stall_count2); end
        for (int k = 1; k <= 6; k++) begin
            issue(1, 1, 3, 1);
            src_used = '0;
            tick();
            issue(0, 0, 0, 0);
            src_reg = 15'd3; src_used = 3'b001;
            tick();
            src_used = '0;
            checks++; if (stall_count !== 16'(k)) begin errors++; $display("FAIL sat_cnt16_%0d: got %0d expected %0d", k, stall_count, k); end
            checks++; if (stall_count2 !== 2'((k > 3) ? 3 : k)) begin errors++; $display("FAIL sat_cnt2_%0d: got %0d expected %0d", k, stall_count2, (k > 3) ? 3 : k); end
        end
        issue(1, 1, 3, 1);
        tick();
        issue(0, 0, 0, 0);
        src_reg = 15'd3; src_used = 3'b001; perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL sat_clr16: got %0d expected 0", stall_count); end
        checks++; if (stall_count2 !== 2'd0) begin errors++; $display("FAIL sat_clr2: got %0d expected 0", stall_count2); end
        drain();
    endtask

    initial begin
        test_reset();
        test_alu_forward();
        test_youngest();
        test_mid_reset();
        test_load_use();
        test_freeze();
        test_r0();
        test_flush();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised forwarding unit that tracks in-flight register writes across DEPTH post-decode pipeline stages in a tag shift register.
- For each of NSRC decode-stage source operands it selects the youngest matching producer stage and muxes that stage's result.
- Raises a load-use stall when the matching producer's data is not yet available.
- Sits between decode and the execute-stage operand muxes. Drives the hazard unit's stall/bubble control and a saturating stall-cycle performance counter.

Parameters:
- REGW, 5, register address width
- DATAW, 32, data width
- NSRC, 3, source operands checked per cycle (rs, rt, store data)
- DEPTH, 3, tracked stages after decode (index 0 = EX, 1 = MEM, 2 = WB)
- LOAD_STAGE, 1, first stage index at which load data is valid (1..DEPTH-1)
- CNTW, 16, stall counter width
- SELW, $clog2(DEPTH+1), select field width (derived)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- issue_valid  in  1  instruction leaving decode this cycle
- issue_wen  in  1  that instruction writes a register
- issue_dest  in  REGW  its destination register
- issue_load  in  1  its result comes from data memory
- advance  in  1  pipeline advances this cycle (low = frozen, e.g. dmem wait)
- flush  in  1  kill instruction entering stage 0
- perf_clr  in  1  synchronous clear of stall_count
- stage_result  in  DEPTH*DATAW  result currently held at each stage, stage i at bits [i*DATAW +: DATAW]
- src_reg  in  NSRC*REGW  decode source registers
- src_used  in  NSRC  source j actually read
- fwd_sel  out  NSRC*SELW  0 = regfile, k = forward from stage k-1
- fwd_data  out  NSRC*DATAW  forwarded value (0 when fwd_sel = 0)
- stall  out  1  load-use hazard; decode must hold
- occupancy  out  SELW  count of valid write-tagged entries
- stall_count  out  CNTW  saturating count of stalled advance cycles

Behaviour:
- State: entries e[0..DEPTH-1], each {valid, wen, dest, load}.
- Reset (nRST low, asynchronous): all valid = 0, stall_count = 0. Combinational outputs then resolve to fwd_sel = 0, fwd_data = 0, stall = 0, occupancy = 0.
- On rising edge with advance = 1:
  - e[i] <= e[i-1] for i >= 1.
  - e[0] <= {1, issue_wen, issue_dest, issue_load} if issue_valid && !stall && !flush; otherwise e[0] <= bubble (valid = 0).
- On rising edge with advance = 0:
  - All entries hold, except flush = 1 clears e[0].valid.
- Match for source j at stage i: e[i].valid && e[i].wen && e[i].dest == src_reg[j] && src_reg[j] != 0 && src_used[j].
- Priority: the youngest (lowest i) match wins. Older matches are ignored even if load-ready.
- Hazard for source j: the winning stage i < LOAD_STAGE && e[i].load.
- Source j outputs, all combinational with zero latency:
  - Hazard: fwd_sel = 0, fwd_data = 0.
  - Else match at stage i: fwd_sel = i+1, fwd_data = stage_result[i].
  - Else (no match): fwd_sel = 0, fwd_data = 0.
- stall = OR of all per-source hazards. Stall depends only on state and src inputs, never on issue_*.
- While stall = 1 and advance = 1, the bubble inserted into e[0] lets the load move to LOAD_STAGE. The stall clears the following cycle (1-cycle stall when LOAD_STAGE = 1).
- occupancy = number of entries with valid && wen.
- stall_count:
  - Increments on an edge where stall && advance.
  - Saturates at 2^CNTW-1.
  - perf_clr takes priority, forcing 0.
- Simultaneous flush and stall: flush wins; e[0] becomes a bubble either way.
- Register 0 is never forwarded and never stalls.
- Reset mid-operation clears all tags immediately. The first post-reset cycle sees no forwarding.

Test Plan:
- Reset, then idle -> fwd_sel = 0, stall = 0, occupancy = 0, stall_count = 0.
- ALU issue writes r5, advance; then src_reg[0] = 5 with stage_result[0] = 0xDEADBEEF -> fwd_sel[0] = 1, fwd_data[0] = 0xDEADBEEF. After one more advance -> fwd_sel[0] = 2.
- Two consecutive writes to r7 (e[0] and e[1]) with src_reg[1] = 7 -> fwd_sel[1] = 1 (youngest wins), not 2.
- Load to r3, advance, consumer reads r3 -> stall = 1 for exactly 1 cycle. e[0] becomes a bubble, then fwd_sel = 2 with load data. stall_count increments by 1.
- Load to r3 with advance held low for 4 cycles -> stall stays 1, tags frozen, stall_count unchanged. On release, normal resolution resumes.
- Write to r0 with src_reg = 0 -> no forward, no stall.
- flush with issue_valid -> occupancy unchanged.
- CNTW = 2, six stalled advances -> stall_count saturates at 3. perf_clr -> 0.
